// File: rtl/systola_pkg.sv
// Shared definitions for the systolic operand path: lane defaults, feeder states, lane slicing.
package systola_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned DW_DEF    = 8;
  localparam int unsigned K_MAX_DEF = 16;

  typedef enum logic [1:0] {
    FEED_IDLE   = 2'd0,
    FEED_STREAM = 2'd1,
    FEED_DRAIN  = 2'd2
  } feed_state_e;

  // LSB of lane `lane` inside a packed N*dw operand word.
  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned dw);
    return lane * dw;
  endfunction

endpackage

// File: rtl/skew_line.sv
// Plain D-stage register delay line with synchronous active-high reset.
module skew_line
  import systola_pkg::*;
#(
  parameter int unsigned D = 1,
  parameter int unsigned W = DW_DEF + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(D); k++) stage_q[k] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int k = 1; k < int'(D); k++) stage_q[k] <= stage_q[k-1];
    end
  end

  assign q_o = stage_q[D-1];

endmodule

// File: rtl/operand_feeder.sv
// Feeds a row of N PEs from a valid/ready operand stream with one cycle of skew per lane.
// Build option FEED_ZERO_GATE_EN: zero a lane's a_out/w_out whenever that lane is not firing.
module operand_feeder
  import systola_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned K_MAX = K_MAX_DEF,
  localparam int unsigned CntW   = $clog2(K_MAX + 1),
  localparam int unsigned DrainW = $clog2(N + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*DW-1:0]   in_a,
  input  logic [N*DW-1:0]   in_w,
  input  logic              in_last,
  output logic [N-1:0]      fire,
  output logic [N*DW-1:0]   a_out,
  output logic [N*DW-1:0]   w_out,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic [CntW-1:0]   beat_cnt
);

  feed_state_e       state_q, state_d;
  logic [CntW-1:0]   beat_cnt_q, beat_cnt_d, cnt_eff;
  logic              err_q, err_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic [N*DW-1:0]   hold_a_q, hold_w_q, src_a, src_w;
  logic              accept, at_limit, is_last;

  assign in_ready = (state_q != FEED_DRAIN);
  assign accept   = in_valid & in_ready;
  // The count is stale in IDLE; a new stream starts counting from zero.
  assign cnt_eff  = (state_q == FEED_IDLE) ? '0 : beat_cnt_q;
  assign at_limit = (cnt_eff == CntW'(K_MAX - 1));
  assign is_last  = in_last | at_limit;

  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = err_q;
    if (accept) begin
      beat_cnt_d = cnt_eff + CntW'(1);
      if (state_q == FEED_IDLE) err_d = 1'b0;
      if (at_limit && !in_last) err_d = 1'b1;
    end
    unique case (state_q)
      FEED_IDLE, FEED_STREAM: begin
        if (accept) begin
          state_d = is_last ? FEED_DRAIN : FEED_STREAM;
          drain_d = '0;
        end
      end
      FEED_DRAIN: begin
        if (drain_q == DrainW'(N - 1)) state_d = FEED_IDLE;
        else                           drain_d = drain_q + DrainW'(1);
      end
      default: state_d = FEED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FEED_IDLE;
      drain_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      hold_a_q   <= '0;
      hold_w_q   <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      if (accept) begin
        hold_a_q <= in_a;
        hold_w_q <= in_w;
      end
    end
  end

  // Bubbles carry the last accepted bytes so idle lanes hold their last fired value.
  assign src_a = accept ? in_a : hold_a_q;
  assign src_w = accept ? in_w : hold_w_q;

  assign busy     = (state_q != FEED_IDLE);
  assign done     = (state_q == FEED_DRAIN) && (drain_q == DrainW'(N - 1));
  assign err_len  = err_q;
  assign beat_cnt = beat_cnt_q;

  for (genvar i = 0; i < int'(N); i++) begin : g_lane
    logic [DW:0] a_tap, w_tap;

    skew_line #(
      .D(i + 1),
      .W(DW + 1)
    ) u_skew_a (
      .clk(clk),
      .rst(rst),
      .d_i({accept, src_a[lane_lsb(i, DW) +: DW]}),
      .q_o(a_tap)
    );

    skew_line #(
      .D(i + 1),
      .W(DW + 1)
    ) u_skew_w (
      .clk(clk),
      .rst(rst),
      .d_i({accept, src_w[lane_lsb(i, DW) +: DW]}),
      .q_o(w_tap)
    );

    assign fire[i] = a_tap[DW] & w_tap[DW];
`ifdef FEED_ZERO_GATE_EN
    assign a_out[lane_lsb(i, DW) +: DW] = fire[i] ? a_tap[DW-1:0] : '0;
    assign w_out[lane_lsb(i, DW) +: DW] = fire[i] ? w_tap[DW-1:0] : '0;
`else
    assign a_out[lane_lsb(i, DW) +: DW] = a_tap[DW-1:0];
    assign w_out[lane_lsb(i, DW) +: DW] = w_tap[DW-1:0];
`endif
  end

endmodule

// File: tb/tb_operand_feeder.sv
// Directed-vector bench for operand_feeder (N=4, DW=8, K_MAX=16); honours FEED_ZERO_GATE_EN.
module tb_operand_feeder;

  localparam int N  = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic [31:0]   in_a, in_w;
  logic [3:0]    fire;
  logic [31:0]   a_out, w_out;
  logic          busy, done, err_len;
  logic [4:0]    beat_cnt;

  int passes = 0;
  int total  = 0;

  always #5 clk = ~clk;

  operand_feeder u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_w(in_w), .in_last(in_last), .fire(fire),
    .a_out(a_out), .w_out(w_out), .busy(busy), .done(done),
    .err_len(err_len), .beat_cnt(beat_cnt)
  );

  typedef struct {
    logic        v;
    logic        last;
    int          beat;
    logic [3:0]  fire;
    logic [31:0] a;
    logic [31:0] w;
    logic        ready;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t tbl_a[8];
  vec_t tbl_b[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Lane i of beat b carries a = 10*b+i, w = a+100.
  task automatic drive(input logic v, input logic last, input int beat);
    in_valid = v;
    in_last  = last;
    for (int i = 0; i < N; i++) begin
      in_a[i*DW +: DW] = 8'(10 * beat + i);
      in_w[i*DW +: DW] = 8'(10 * beat + i + 100);
    end
  endtask

  function automatic logic [31:0] gate(input logic [31:0] val, input logic [3:0] f);
    logic [31:0] r;
    r = val;
`ifdef FEED_ZERO_GATE_EN
    for (int i = 0; i < N; i++) if (!f[i]) r[i*DW +: DW] = '0;
`endif
    return r;
  endfunction

  task automatic do_reset();
    drive(1'b0, 1'b0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic apply_vec(input vec_t vec, input string tag, input int k);
    drive(vec.v, vec.last, vec.beat);
    @(negedge clk);
    check($sformatf("%s[%0d] fire", tag, k), 64'(fire), 64'(vec.fire));
    check($sformatf("%s[%0d] a_out", tag, k), 64'(a_out), 64'(gate(vec.a, vec.fire)));
    check($sformatf("%s[%0d] w_out", tag, k), 64'(w_out), 64'(gate(vec.w, vec.fire)));
    check($sformatf("%s[%0d] in_ready", tag, k), 64'(in_ready), 64'(vec.ready));
    check($sformatf("%s[%0d] done", tag, k), 64'(done), 64'(vec.done));
    check($sformatf("%s[%0d] busy", tag, k), 64'(busy), 64'(vec.busy));
    @(posedge clk);
    #1;
  endtask

  // 16 back-to-back beats; last_final selects whether the 16th carries in_last.
  task automatic run_kmax(input logic last_final);
    int done_cyc;
    done_cyc = -1;
    do_reset();
    for (int b = 0; b < 16; b++) begin
      drive(1'b1, last_final && (b == 15), b);
      if (b == 15) begin
        @(negedge clk);
        check("kmax pre ready", 64'(in_ready), 64'd1);
        check("kmax pre cnt", 64'(beat_cnt), 64'd15);
        check("kmax pre err", 64'(err_len), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    for (int c = 16; c < 26; c++) begin
      drive(1'b0, 1'b0, 0);
      @(negedge clk);
      if (c == 16) begin
        check("kmax err", 64'(err_len), 64'(!last_final));
        check("kmax ready", 64'(in_ready), 64'd0);
        check("kmax cnt", 64'(beat_cnt), 64'd16);
      end
      if (done && done_cyc < 0) done_cyc = c;
      @(posedge clk);
      #1;
    end
    check("kmax done cycle", 64'(done_cyc), 64'(19));
    check("kmax idle err", 64'(err_len), 64'(!last_final));
    check("kmax idle cnt", 64'(beat_cnt), 64'd16);
    if (!last_final) begin
      drive(1'b1, 1'b1, 0);
      @(posedge clk);
      #1 drive(1'b0, 1'b0, 0);
      @(negedge clk);
      check("kmax clear err", 64'(err_len), 64'd0);
      check("kmax restart cnt", 64'(beat_cnt), 64'd1);
    end
  endtask

  initial begin
    int done_seen;
    //          v     last  beat fire     a             w             rdy   done  busy
    tbl_a[0] = '{1'b1, 1'b0, 0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl_a[1] = '{1'b1, 1'b0, 1, 4'b0001, 32'h00000000, 32'h00000064, 1'b1, 1'b0, 1'b1};
    tbl_a[2] = '{1'b1, 1'b1, 2, 4'b0011, 32'h0000010A, 32'h0000656E, 1'b1, 1'b0, 1'b1};
    tbl_a[3] = '{1'b0, 1'b0, 0, 4'b0111, 32'h00020B14, 32'h00666F78, 1'b0, 1'b0, 1'b1};
    tbl_a[4] = '{1'b1, 1'b0, 5, 4'b1110, 32'h030C1514, 32'h67707978, 1'b0, 1'b0, 1'b1};
    tbl_a[5] = '{1'b1, 1'b0, 5, 4'b1100, 32'h0D161514, 32'h717A7978, 1'b0, 1'b0, 1'b1};
    tbl_a[6] = '{1'b0, 1'b0, 0, 4'b1000, 32'h17161514, 32'h7B7A7978, 1'b0, 1'b1, 1'b1};
    tbl_a[7] = '{1'b0, 1'b0, 0, 4'b0000, 32'h17161514, 32'h7B7A7978, 1'b1, 1'b0, 1'b0};

    tbl_b[0] = '{1'b1, 1'b0, 0, 4'b0000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0};
    tbl_b[1] = '{1'b0, 1'b0, 0, 4'b0001, 32'h00000000, 32'h00000064, 1'b1, 1'b0, 1'b1};
    tbl_b[2] = '{1'b1, 1'b0, 1, 4'b0010, 32'h00000100, 32'h00006564, 1'b1, 1'b0, 1'b1};
    tbl_b[3] = '{1'b1, 1'b1, 2, 4'b0101, 32'h0002010A, 32'h0066656E, 1'b1, 1'b0, 1'b1};
    tbl_b[4] = '{1'b0, 1'b0, 0, 4'b1011, 32'h03020B14, 32'h67666F78, 1'b0, 1'b0, 1'b1};
    tbl_b[5] = '{1'b0, 1'b0, 0, 4'b0110, 32'h030C1514, 32'h67707978, 1'b0, 1'b0, 1'b1};
    tbl_b[6] = '{1'b0, 1'b0, 0, 4'b1100, 32'h0D161514, 32'h717A7978, 1'b0, 1'b0, 1'b1};
    tbl_b[7] = '{1'b0, 1'b0, 0, 4'b1000, 32'h17161514, 32'h7B7A7978, 1'b0, 1'b1, 1'b1};
    tbl_b[8] = '{1'b0, 1'b0, 0, 4'b0000, 32'h17161514, 32'h7B7A7978, 1'b1, 1'b0, 1'b0};

    // Reset state
    do_reset();
    @(negedge clk);
    check("rst fire", 64'(fire), 64'd0);
    check("rst a_out", 64'(a_out), 64'd0);
    check("rst w_out", 64'(w_out), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst err", 64'(err_len), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst ready", 64'(in_ready), 64'd1);
    check("rst cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk);
    #1;

    // 3-beat stream; beats offered during drain must be ignored
    for (int k = 0; k < 8; k++) apply_vec(tbl_a[k], "stream3", k);
    check("stream3 beat_cnt", 64'(beat_cnt), 64'd3);

    // Bubble in the middle of a 3-beat stream
    do_reset();
    for (int k = 0; k < 9; k++) apply_vec(tbl_b[k], "bubble", k);
    check("bubble beat_cnt", 64'(beat_cnt), 64'd3);

    run_kmax(1'b0);
    run_kmax(1'b1);

    // Reset in the middle of a 5-beat stream
    do_reset();
    drive(1'b1, 1'b0, 0);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 1);
    @(posedge clk);
    #1 drive(1'b1, 1'b0, 2);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b0, 1'b0, 0);
    @(negedge clk);
    check("midrst fire", 64'(fire), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst ready", 64'(in_ready), 64'd1);
    check("midrst cnt", 64'(beat_cnt), 64'd0);
    done_seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (done || fire != 4'b0000) done_seen++;
    end
    check("midrst quiet", 64'(done_seen), 64'd0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/operand_feeder.md
Name: operand_feeder

Overview:
- Transmit-side counterpart of the PE operand interface.
- Accepts wide operand beats, one activation and one weight byte per lane, over a valid/ready stream.
- Drives a row of N PEs with per-lane fire/a/w, skewed by one cycle per lane, as the array edge requires.
- Sequences start, stream, drain and done, and flags over-length streams.

Parameters:
- N, 4, number of PE lanes driven.
- DW, 8, operand width per lane (matches PE a/w width).
- K_MAX, 16, maximum beats per stream; the K_MAX-th beat is forced to be last.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  beat offered.
- in_ready  output  1  beat accepted when in_valid&&in_ready.
- in_a  input  N*DW  activations, lane i = bits [i*DW +: DW].
- in_w  input  N*DW  weights, same packing.
- in_last  input  1  final beat of stream.
- fire  output  N  per-lane PE fire.
- a_out  output  N*DW  per-lane activation to PE.
- w_out  output  N*DW  per-lane weight to PE.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse, last beat on lane N-1.
- err_len  output  1  sticky: stream hit K_MAX without in_last.
- beat_cnt  output  $clog2(K_MAX+1)  beats accepted in current stream.

Behaviour:
- Reset (rst=1 at posedge): all skew registers, fire, a_out, w_out, done, err_len and beat_cnt go to 0; state=IDLE. Reset overrides everything, including mid-stream: next cycle fire=0 on all lanes and in_ready=1.
- States:
  - IDLE: in_ready=1; an accept goes to STREAM, or to DRAIN if the accept is last.
  - STREAM: in_ready=1; a last accept goes to DRAIN.
  - DRAIN: in_ready=0 for N cycles, then IDLE.
- A beat is "last" if in_last=1 or beat_cnt==K_MAX-1 at accept.
- Latency: a beat accepted at cycle t appears on lane i (fire_i=1, a_out/w_out = its lane-i bytes) at cycle t+1+i.
- Bubble: a cycle in IDLE/STREAM with no accept inserts fire=0 into the lane-0 stage; the bubble propagates with the same skew.
- DRAIN: no new beats enter; skew registers continue shifting, with fire=0 entering lane 0.
- done: asserted exactly at cycle t+N for the last beat accepted at t, coincident with lane N-1's last fire. in_ready returns to 1 at t+N+1.
- beat_cnt:
  - Increments per accept.
  - Cleared on the first accept from IDLE, which loads it to 1.
  - Holds its value through DRAIN and IDLE until the next stream starts.
- err_len:
  - Set when the K_MAX-th beat is accepted with in_last=0.
  - If K_MAX-th beat has in_last=1: no error.
  - Cleared on the next accept from IDLE or on rst.
- Simultaneous: an accept from IDLE with in_last=1 is a single-beat stream; it goes straight to DRAIN.
- in_ready is a function of state only, with no combinational path from in_valid.

Optional Feature:
- Macro FEED_ZERO_GATE_EN.
- Defined: a lane's a_out/w_out are forced to 0 whenever that lane's fire=0 (bubble, drain, idle).
- Undefined: a lane's a_out/w_out hold the last fired value while fire=0.
- fire timing is identical in both builds.

Decomposition:
- Shared package systola_pkg:
  - DW and N defaults.
  - State enum FEED_IDLE/FEED_STREAM/FEED_DRAIN.
  - Lane-slice helper constants.
- Sub-module skew_line: parameterised depth D and width DW+1 (fire + data), a plain register delay chain with synchronous active-high reset. It is instantiated per lane for the a-path and the w-path, with D=i+1 for lane i.

Test Plan:
- Reset: hold rst 2 cycles -> fire=0, a_out=w_out=0, done=0, err_len=0, busy=0, in_ready=1.
- 3-beat stream, N=4: beats at cycles 0,1,2; lane-i bytes = 10*b+i for beat b; in_last on beat 2.
  - Lane0 fires cycles 1-3 with a=0,10,20.
  - Lane3 fires cycles 4-6 with a=3,13,23.
  - in_ready=0 in cycles 3-6; done=1 only at cycle 6; beat_cnt=3.
- Bubble: in_valid low at cycle 1 of a 3-beat stream -> each lane i shows fire=1,0,1,1 starting at cycle 1+i; done at cycle 7.
- Over-length, K_MAX=16: 16 beats, in_last never set -> beat 16 treated as last; err_len=1 from the cycle after it; done 4 cycles after it. The next stream's first accept clears err_len.
- Reset mid-stream: rst at cycle 2 of a 5-beat stream -> cycle 3 has all fire=0 and state IDLE; no done pulse occurs.
- Macro check: repeat the bubble test.
  - With FEED_ZERO_GATE_EN: bubble slot a_out=w_out=0.
  - Without: bubble slot holds the previous beat's bytes (lane0 a=0).
